// File: rtl/peb_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : peb_trace_pkg
//  Description : Shared types for the PEB trace-capture unit: record type,
//                capture state encoding and segment-tag layout.
//  Revision    : 1.0  initial release
// ============================================================================
package peb_trace_pkg;

    // Segment tag field widths: {layer, patch, ftrgrp}
    localparam int c_LAYER_W  = 6;
    localparam int c_PATCH_W  = 6;
    localparam int c_FTRGRP_W = 6;

    // Record type carried in the MSB of every trace record
    typedef enum logic {
        c_REC_DATA = 1'b0,
        c_REC_MARK = 1'b1
    } rec_type_e;

    // Capture state, explicitly encoded (visible on the State port)
    typedef enum logic [1:0] {
        c_ST_IDLE    = 2'b00,
        c_ST_CAPTURE = 2'b01,
        c_ST_STOPPED = 2'b10
    } state_e;

    typedef struct packed {
        logic [c_LAYER_W-1:0]  layer;
        logic [c_PATCH_W-1:0]  patch;
        logic [c_FTRGRP_W-1:0] ftrgrp;
    } seg_tag_t;

    // Assemble a segment tag from its three fields
    function automatic seg_tag_t build_tag(input logic [c_LAYER_W-1:0]  layer,
                                           input logic [c_PATCH_W-1:0]  patch,
                                           input logic [c_FTRGRP_W-1:0] ftrgrp);
        seg_tag_t v_tag;
        v_tag.layer  = layer;
        v_tag.patch  = patch;
        v_tag.ftrgrp = ftrgrp;
        return v_tag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : trace_rr_arbiter
//  Description : Round-robin arbiter over channel holding registers with a
//                pending segment marker taking absolute priority.
//  Revision    : 1.0  initial release
// ============================================================================
module trace_rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_mark_req,
    input  logic              i_accept,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [CH_W-1:0]   o_gnt_idx,
    output logic              o_any
);

    // r_ptr is the first channel searched, i.e. one past the last grant
    logic [CH_W-1:0] r_ptr;
    logic [CH_W:0]   w_sum;
    logic [CH_W:0]   w_ptr_nxt;
    logic            w_found;

    assign o_any = i_mark_req | (|i_req);

    // Rotating search from r_ptr; a pending marker suppresses data grants
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_sum = {1'b0, r_ptr} + (CH_W+1)'(k);
            if (w_sum >= (CH_W+1)'(NUM_CH)) w_sum = w_sum - (CH_W+1)'(NUM_CH);
            if (!w_found && i_req[w_sum[CH_W-1:0]]) begin
                w_found                   = 1'b1;
                o_gnt[w_sum[CH_W-1:0]]    = 1'b1;
                o_gnt_idx                 = w_sum[CH_W-1:0];
            end
        end
        if (i_mark_req) begin
            o_gnt     = '0;
            o_gnt_idx = '0;
        end
    end

    // Pointer value following the current grant, wrapped to NUM_CH
    always_comb begin
        w_ptr_nxt = {1'b0, o_gnt_idx} + (CH_W+1)'(1);
        if (w_ptr_nxt >= (CH_W+1)'(NUM_CH)) w_ptr_nxt = '0;
    end

    // Advance only when a data grant is actually consumed by a FIFO write
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_ptr <= '0;
        end else if (i_accept && !i_mark_req && (|i_req)) begin
            r_ptr <= w_ptr_nxt[CH_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/peb_trace_capture.sv
`default_nettype none
// ============================================================================
//  Module      : peb_trace_capture
//  Description : Snoops NUM_CH valid/ready channels, timestamps each completed
//                beat, interleaves segment markers and buffers the records in
//                an on-chip trace FIFO drained through a valid/ready port.
//  Revision    : 1.0  initial release
// ============================================================================
module peb_trace_capture
    import peb_trace_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_WIDTH = 128,
    parameter  int TS_WIDTH   = 16,
    parameter  int DEPTH      = 64,
    parameter  int TAG_WIDTH  = 18,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int REC_W      = 1 + CH_W + TS_WIDTH + DATA_WIDTH,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Arm,
    input  logic                         Stop,
    input  logic                         Mode_Wrap,
    input  logic [NUM_CH-1:0]            Ch_En,
    input  logic [NUM_CH-1:0]            Mon_Val,
    input  logic [NUM_CH-1:0]            Mon_Rdy,
    input  logic [NUM_CH*DATA_WIDTH-1:0] Mon_Data,
    input  logic                         Seg_Start,
    input  logic [TAG_WIDTH-1:0]         Seg_Tag,
    output logic                         Rd_Val,
    input  logic                         Rd_Rdy,
    output logic [REC_W-1:0]             Rd_Data,
    output logic [CNT_W-1:0]             Count,
    output logic [15:0]                  Drop_Cnt,
    output logic [1:0]                   State
);

    localparam int c_AW = $clog2(DEPTH);

    state_e                r_state, w_state_nxt;
    logic [TS_WIDTH-1:0]   r_ts;
    logic [NUM_CH-1:0]     r_hold_v;
    logic [DATA_WIDTH-1:0] r_hold_data [NUM_CH];
    logic [TS_WIDTH-1:0]   r_hold_ts   [NUM_CH];
    logic                  r_mark_v;
    logic [TAG_WIDTH-1:0]  r_mark_tag;
    logic [TS_WIDTH-1:0]   r_mark_ts;
    logic [REC_W-1:0]      r_mem [DEPTH];
    logic [c_AW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [15:0]           r_drop;

    logic                  w_cap, w_seg, w_full, w_empty, w_pop;
    logic                  w_any, w_wr_req, w_block, w_wr, w_ovw;
    logic [NUM_CH-1:0]     w_beat, w_gnt, w_done, w_drops;
    logic [CH_W-1:0]       w_gnt_idx;
    logic [REC_W-1:0]      w_wr_rec;
    logic [4:0]            w_drop_inc;
    logic [16:0]           w_drop_sum;
    logic [15:0]           w_drop_nxt;

    function automatic logic [REC_W-1:0] build_rec(input rec_type_e             t,
                                                   input logic [CH_W-1:0]       ch,
                                                   input logic [TS_WIDTH-1:0]   ts,
                                                   input logic [DATA_WIDTH-1:0] payload);
        return {t, ch, ts, payload};
    endfunction

    // Arm pre-empts all capture activity in its cycle since it clears everything
    assign w_cap    = (r_state == c_ST_CAPTURE) && !Arm;
    assign w_beat   = Mon_Val & Mon_Rdy & Ch_En & {NUM_CH{w_cap}};
    assign w_seg    = Seg_Start && w_cap;
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_pop    = Rd_Rdy && !w_empty && !Arm;
    assign w_wr_req = w_any && !Arm;
    assign w_block  = w_wr_req && w_full && !w_pop && !Mode_Wrap;
    assign w_wr     = w_wr_req && !w_block;
    assign w_ovw    = w_wr && w_full && !w_pop;
    assign w_done   = w_gnt & {NUM_CH{w_wr}};
    assign w_drops  = w_beat & r_hold_v & ~w_done;

    assign w_wr_rec = r_mark_v
        ? build_rec(c_REC_MARK, '0, r_mark_ts, DATA_WIDTH'(r_mark_tag))
        : build_rec(c_REC_DATA, w_gnt_idx, r_hold_ts[w_gnt_idx], r_hold_data[w_gnt_idx]);

    trace_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk        (Clk),
        .rst        (Rst),
        .i_clr      (Arm),
        .i_req      (r_hold_v),
        .i_mark_req (r_mark_v),
        .i_accept   (w_wr),
        .o_gnt      (w_gnt),
        .o_gnt_idx  (w_gnt_idx),
        .o_any      (w_any)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: Arm dominates Stop; a blocked write in no-wrap mode stops capture
    always_comb begin
        w_state_nxt = r_state;
        if (Arm) begin
            w_state_nxt = c_ST_CAPTURE;
        end else if ((r_state == c_ST_CAPTURE) && (Stop || w_block)) begin
            w_state_nxt = c_ST_STOPPED;
        end
    end

    // Free-running timestamp, counting only while capturing
    always_ff @(posedge Clk) begin
        if (Rst || Arm)                    r_ts <= '0;
        else if (r_state == c_ST_CAPTURE)  r_ts <= r_ts + TS_WIDTH'(1);
    end

    // Per-channel holding registers; a granted register may be refilled at once
    always_ff @(posedge Clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (Rst || Arm) begin
                r_hold_v[i] <= 1'b0;
            end else if (w_beat[i] && (!r_hold_v[i] || w_done[i])) begin
                r_hold_v[i]    <= 1'b1;
                r_hold_data[i] <= Mon_Data[i*DATA_WIDTH +: DATA_WIDTH];
                r_hold_ts[i]   <= r_ts;
            end else if (w_done[i]) begin
                r_hold_v[i] <= 1'b0;
            end
        end
    end

    // One-deep marker slot; the timestamp is taken when the segment starts
    always_ff @(posedge Clk) begin
        if (Rst || Arm) begin
            r_mark_v   <= 1'b0;
            r_mark_tag <= '0;
            r_mark_ts  <= '0;
        end else if (w_seg) begin
            r_mark_v   <= 1'b1;
            r_mark_tag <= Seg_Tag;
            r_mark_ts  <= r_ts;
        end else if (w_wr && r_mark_v) begin
            r_mark_v   <= 1'b0;
        end
    end

    // Trace storage array (contents are don't-care while unoccupied)
    always_ff @(posedge Clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_wr_rec;
    end

    // FIFO pointers and occupancy; an overwrite retires the oldest entry
    always_ff @(posedge Clk) begin
        if (Rst || Arm) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)           r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop || w_ovw) r_rd_ptr <= r_rd_ptr + c_AW'(1);
            if (w_wr && !w_pop && !w_ovw) r_count <= r_count + CNT_W'(1);
            else if (!w_wr && w_pop)      r_count <= r_count - CNT_W'(1);
        end
    end

    // Lost beats this cycle: holding-register collisions plus any overwrite
    always_comb begin
        w_drop_inc = {4'b0, w_ovw};
        for (int i = 0; i < NUM_CH; i++) begin
            w_drop_inc = w_drop_inc + {4'b0, w_drops[i]};
        end
        w_drop_sum = {1'b0, r_drop} + {12'b0, w_drop_inc};
        w_drop_nxt = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    // Saturating drop counter
    always_ff @(posedge Clk) begin
        if (Rst || Arm) r_drop <= '0;
        else            r_drop <= w_drop_nxt;
    end

    assign Rd_Val   = !w_empty;
    assign Rd_Data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign Count    = r_count;
    assign Drop_Cnt = r_drop;
    assign State    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_peb_trace_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_peb_trace_capture
//  Description : Directed self-checking bench for peb_trace_capture with
//                hand-computed expected records.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_peb_trace_capture;
    import peb_trace_pkg::*;

    localparam int c_NCH = 4;
    localparam int c_DW  = 128;
    localparam int c_RW  = 1 + 2 + 16 + c_DW;

    logic                   Clk = 1'b0;
    logic                   Rst, Arm, Stop, Mode_Wrap, Seg_Start, Rd_Rdy;
    logic [c_NCH-1:0]       Ch_En, Mon_Val, Mon_Rdy;
    logic [c_NCH*c_DW-1:0]  Mon_Data;
    logic [17:0]            Seg_Tag;
    logic                   Rd_Val;
    logic [c_RW-1:0]        Rd_Data;
    logic [6:0]             Count;
    logic [15:0]            Drop_Cnt;
    logic [1:0]             State;

    int n_cmp = 0;
    int n_err = 0;

    peb_trace_capture dut (
        .Clk(Clk), .Rst(Rst), .Arm(Arm), .Stop(Stop), .Mode_Wrap(Mode_Wrap),
        .Ch_En(Ch_En), .Mon_Val(Mon_Val), .Mon_Rdy(Mon_Rdy), .Mon_Data(Mon_Data),
        .Seg_Start(Seg_Start), .Seg_Tag(Seg_Tag), .Rd_Val(Rd_Val), .Rd_Rdy(Rd_Rdy),
        .Rd_Data(Rd_Data), .Count(Count), .Drop_Cnt(Drop_Cnt), .State(State)
    );

    always #5 Clk = ~Clk;

    task automatic chk_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [c_RW-1:0] rec(input logic t, input logic [1:0] ch,
                                            input logic [15:0] ts, input logic [127:0] d);
        return {t, ch, ts, d};
    endfunction

    task automatic arm();
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
    endtask

    logic [127:0] c_d2;
    logic [127:0] c_d1;

    initial begin
        Rst = 1'b1; Arm = 1'b0; Stop = 1'b0; Mode_Wrap = 1'b0; Seg_Start = 1'b0;
        Rd_Rdy = 1'b0; Ch_En = '1; Mon_Val = '0; Mon_Rdy = '1; Mon_Data = '0; Seg_Tag = '0;
        c_d2 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_66A5;
        c_d1 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
        tick(); tick();
        Rst = 1'b0;

        // ---- reset state
        chk_val("rst_state", State, 2'b00);
        chk_val("rst_rdval", Rd_Val, 1'b0);
        chk_val("rst_count", Count, 7'd0);
        chk_val("rst_drop",  Drop_Cnt, 16'd0);
        chk_val("rst_rddata", Rd_Data, '0);

        // ---- single beat on ch2 at ts=5; ch3 valid but disabled
        arm();
        chk_val("arm_state", State, 2'b01);
        repeat (5) tick();
        Ch_En = 4'b0111;
        Mon_Val = 4'b1100;
        Mon_Data[2*c_DW +: c_DW] = c_d2;
        Mon_Data[3*c_DW +: c_DW] = 128'h77;
        tick();
        Mon_Val = '0; Ch_En = '1;
        chk_val("t1_not_yet", Rd_Val, 1'b0);
        tick();
        chk_val("t1_rdval", Rd_Val, 1'b1);
        chk_val("t1_count", Count, 7'd1);
        chk_val("t1_rec", Rd_Data, rec(1'b0, 2'd2, 16'd5, c_d2));
        Rd_Rdy = 1'b1;
        tick();
        Rd_Rdy = 1'b0;
        chk_val("t1_pop_count", Count, 7'd0);
        chk_val("t1_pop_rdval", Rd_Val, 1'b0);

        // ---- all four channels, two back-to-back bursts
        arm();
        Mon_Val = '1;
        for (int i = 0; i < c_NCH; i++) Mon_Data[i*c_DW +: c_DW] = 128'h1000 + 128'(i);
        tick();
        for (int i = 0; i < c_NCH; i++) Mon_Data[i*c_DW +: c_DW] = 128'h2000 + 128'(i);
        tick();
        Mon_Val = '0;
        chk_val("t2_drop", Drop_Cnt, 16'd3);
        repeat (4) tick();
        chk_val("t2_count", Count, 7'd5);
        chk_val("t2_r0", Rd_Data, rec(1'b0, 2'd0, 16'd0, 128'h1000));
        tick();
        chk_val("t2_hold", Rd_Data, rec(1'b0, 2'd0, 16'd0, 128'h1000));
        Rd_Rdy = 1'b1;
        tick();
        chk_val("t2_r1", Rd_Data, rec(1'b0, 2'd1, 16'd0, 128'h1001));
        tick();
        chk_val("t2_r2", Rd_Data, rec(1'b0, 2'd2, 16'd0, 128'h1002));
        tick();
        chk_val("t2_r3", Rd_Data, rec(1'b0, 2'd3, 16'd0, 128'h1003));
        tick();
        chk_val("t2_r4", Rd_Data, rec(1'b0, 2'd0, 16'd1, 128'h2000));
        tick();
        Rd_Rdy = 1'b0;
        chk_val("t2_empty", Count, 7'd0);

        // ---- segment marker alongside a ch1 beat at ts=2
        arm();
        tick(); tick();
        Seg_Start = 1'b1;
        Seg_Tag = build_tag(6'd3, 6'd1, 6'd2);
        Mon_Val = 4'b0010;
        Mon_Data[1*c_DW +: c_DW] = c_d1;
        tick();
        Seg_Start = 1'b0; Mon_Val = '0;
        tick(); tick();
        chk_val("t3_count", Count, 7'd2);
        chk_val("t3_mark", Rd_Data, rec(1'b1, 2'd0, 16'd2, 128'h03042));
        Rd_Rdy = 1'b1;
        tick();
        Rd_Rdy = 1'b0;
        chk_val("t3_data", Rd_Data, rec(1'b0, 2'd1, 16'd2, c_d1));
        chk_val("t3_drop", Drop_Cnt, 16'd0);

        // ---- wrap mode: 70 beats on ch0, no reads
        Mode_Wrap = 1'b1;
        arm();
        chk_val("t4_arm_count", Count, 7'd0);
        for (int k = 1; k <= 70; k++) begin
            Mon_Val = 4'b0001;
            Mon_Data[0 +: c_DW] = 128'(k);
            tick();
        end
        Mon_Val = '0;
        tick();
        chk_val("t4_count", Count, 7'd64);
        chk_val("t4_drop", Drop_Cnt, 16'd6);
        chk_val("t4_first", Rd_Data, rec(1'b0, 2'd0, 16'd6, 128'd7));
        Rd_Rdy = 1'b1;
        tick();
        Rd_Rdy = 1'b0;
        chk_val("t4_second", Rd_Data, rec(1'b0, 2'd0, 16'd7, 128'd8));
        chk_val("t4_count_pop", Count, 7'd63);

        // ---- stop-on-full: beat 65 blocked, beat 66 collides, rest arrive while stopped
        Mode_Wrap = 1'b0;
        arm();
        for (int k = 1; k <= 70; k++) begin
            Mon_Val = 4'b0001;
            Mon_Data[0 +: c_DW] = 128'(k);
            tick();
        end
        Mon_Val = '0;
        tick();
        chk_val("t5_state", State, 2'b10);
        chk_val("t5_count", Count, 7'd64);
        chk_val("t5_drop", Drop_Cnt, 16'd1);
        chk_val("t5_first", Rd_Data, rec(1'b0, 2'd0, 16'd0, 128'd1));
        Seg_Start = 1'b1;
        tick();
        Seg_Start = 1'b0;
        tick();
        chk_val("t5_seg_ignored", Count, 7'd64);
        arm();
        chk_val("t5_rearm_state", State, 2'b01);
        chk_val("t5_rearm_count", Count, 7'd0);
        chk_val("t5_rearm_drop", Drop_Cnt, 16'd0);

        // ---- reset mid-capture with 10 records held, then Arm+Stop together
        Mode_Wrap = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            Mon_Val = 4'b0001;
            Mon_Data[0 +: c_DW] = 128'(k);
            tick();
        end
        Mon_Val = '0;
        tick();
        chk_val("t6_count", Count, 7'd10);
        Rst = 1'b1; Arm = 1'b1; Mon_Val = '1;
        tick();
        Rst = 1'b0; Arm = 1'b0; Mon_Val = '0;
        chk_val("t6_rdval", Rd_Val, 1'b0);
        chk_val("t6_count0", Count, 7'd0);
        chk_val("t6_state", State, 2'b00);
        Arm = 1'b1; Stop = 1'b1;
        tick();
        Arm = 1'b0; Stop = 1'b0;
        chk_val("t6_armstop", State, 2'b01);
        tick();
        chk_val("t6_no_capture", Count, 7'd0);
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        chk_val("t6_stop", State, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
